// File: rtl/aes_128_decrypt_iter.sv
// aes_128_decrypt_iter: iterative AES-128 decryption, one round per clock.
// Round keys are produced on the fly. A forward expansion runs k0 -> k10,
// then the inverse key schedule walks k10 -> k0 while the rounds run.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   ciphertext + key handshake (in_ready = IDLE)
//   state, key            128-bit ciphertext and cipher key, [127:120] = byte 0
//   out_valid / out_ready plaintext handshake, out held while out_valid
//   out                   128-bit registered plaintext
module aes_128_decrypt_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out
);

  localparam logic [1:0] IDLE = 2'd0, EXPAND = 2'd1, ROUND = 2'd2, DONE = 2'd3;

  logic [1:0]   fsm_q, fsm_d;
  logic [127:0] s_q, s_d, k_q, k_d, out_q, out_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         out_valid_q, out_valid_d;

  // ---------------- GF(2^8) helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 = a^-1 (and 0 -> 0) via an addition chain: 254 = 240 + 12 + 2
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240;
    a2   = gmul(a, a);
    a3   = gmul(a2, a);
    a6   = gmul(a3, a3);
    a12  = gmul(a6, a6);
    a15  = gmul(a12, a3);
    a30  = gmul(a15, a15);
    a60  = gmul(a30, a30);
    a120 = gmul(a60, a60);
    a240 = gmul(a120, a120);
    return gmul(gmul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ rl(v, 3'd1) ^ rl(v, 3'd2) ^ rl(v, 3'd3) ^ rl(v, 3'd4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rl(x, 3'd1) ^ rl(x, 3'd3) ^ rl(x, 3'd6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- key path (4 shared forward S-boxes) ----------------
  // Both schedules need SubWord(RotWord(w)): forward uses w3 of the current
  // key, inverse uses the recovered w3' = w7 ^ w6, so one S-box row serves both.
  logic [31:0]  sw_in, sw_rot, sw_out, t_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] k_fwd, k_inv;
  logic [3:0]   rc_idx;

  always_comb begin
    sw_in  = (fsm_q == ROUND) ? (k_q[31:0] ^ k_q[63:32]) : k_q[31:0];
    sw_rot = {sw_in[23:0], sw_in[31:24]};
    sw_out = '0;
    for (int j = 0; j < 4; j++) sw_out[8*j +: 8] = sbox(sw_rot[8*j +: 8]);
    rc_idx = (fsm_q == ROUND) ? rnd_q : rnd_q + 4'd1;
    t_word = sw_out ^ {rcon(rc_idx), 24'h0};
    n0     = k_q[127:96] ^ t_word;
    n1     = k_q[95:64] ^ n0;
    n2     = k_q[63:32] ^ n1;
    n3     = k_q[31:0] ^ n2;
    k_fwd  = {n0, n1, n2, n3};
    k_inv  = {k_q[127:96] ^ t_word, k_q[95:64] ^ k_q[127:96],
              k_q[63:32] ^ k_q[95:64], k_q[31:0] ^ k_q[63:32]};
  end

  // ---------------- inverse round ----------------
  logic [127:0] isr, ark, imc, rnd_res;

  always_comb begin
    isr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        isr[127-8*(4*c+r) -: 8] = s_q[127-8*(4*((c-r+4)%4)+r) -: 8];
    ark = '0;
    for (int i = 0; i < 16; i++) ark[8*i +: 8] = inv_sbox(isr[8*i +: 8]);
    ark = ark ^ k_inv;
    imc = '0;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = ark[127-32*c -: 8];
      a1 = ark[119-32*c -: 8];
      a2 = ark[111-32*c -: 8];
      a3 = ark[103-32*c -: 8];
      imc[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      imc[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      imc[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      imc[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    // last round (rnd == 1) has no InvMixColumns
    rnd_res = (rnd_q == 4'd1) ? ark : imc;
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      s_q         <= '0;
      k_q         <= '0;
      rnd_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      s_q         <= s_d;
      k_q         <= k_d;
      rnd_q       <= rnd_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // ---------------- next-state ----------------
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (in_valid) fsm_d = EXPAND;
      EXPAND:  if (rnd_q == 4'd9) fsm_d = ROUND;
      ROUND:   if (rnd_q == 4'd1) fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // ---------------- datapath / outputs ----------------
  always_comb begin
    s_d         = s_q;
    k_d         = k_q;
    rnd_d       = rnd_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      IDLE: if (in_valid) begin
        s_d   = state;
        k_d   = key;
        rnd_d = 4'd0;
      end
      EXPAND: begin
        k_d   = k_fwd;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd9) s_d = s_q ^ k_fwd;  // initial AddRoundKey with k10
      end
      ROUND: begin
        s_d   = rnd_res;
        k_d   = k_inv;
        rnd_d = rnd_q - 4'd1;
        if (rnd_q == 4'd1) begin
          out_d       = rnd_res;
          out_valid_d = 1'b1;
        end
      end
      DONE: if (out_ready) out_valid_d = 1'b0;
      default: ;
    endcase
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule
